// File: rtl/bus_router.sv
// Data-bus router: decodes the shared address into NWIN windows, muxes slave read
// data back with RD_LAT latency and arbitrates between the CPU and bounded DMA bursts.
module bus_router #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int NWIN   = 4,
    parameter int RD_LAT = 0,
    parameter int BURST  = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [AW-1:0]        cpu_a,
    input  logic [DW-1:0]        cpu_o,
    input  logic                 cpu_w,
    input  logic                 cpu_r,
    output logic [DW-1:0]        cpu_i,
    output logic                 cpu_ce,
    input  logic                 dma_req,
    input  logic [AW-1:0]        dma_a,
    input  logic [DW-1:0]        dma_o,
    input  logic                 dma_w,
    output logic                 dma_gnt,
    output logic                 dma_ack,
    output logic [DW-1:0]        dma_i,
    input  logic [NWIN*AW-1:0]   win_base,
    input  logic [NWIN*AW-1:0]   win_limit,
    output logic [AW-1:0]        s_a,
    output logic [DW-1:0]        s_d,
    output logic [NWIN-1:0]      s_sel,
    output logic [NWIN-1:0]      s_w,
    input  logic [NWIN*DW-1:0]   s_q,
    output logic                 err,
    output logic [1:0]           dbg_state,
    output logic                 dbg_block
);

    // DMA handshake: the master raises dma_req and keeps dma_a/dma_o/dma_w stable
    // until dma_ack; each dma_ack cycle completes one beat (read data valid on dma_i).
    // Dropping dma_req ends the burst once any outstanding read has been acked.

    typedef enum logic [1:0] {
        S_CPU      = 2'd0,
        S_CPU_WAIT = 2'd1,
        S_DMA      = 2'd2,
        S_DMA_WAIT = 2'd3
    } state_t;

    localparam int             IW       = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int             BW       = $clog2(BURST + 1);
    localparam logic [1:0]     CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
    localparam logic [BW-1:0]  BURST_N  = BW'(BURST);
    localparam bit             RD_STALL = (RD_LAT > 0);

    typedef struct packed {
        logic          vld;
        logic          dma;
        logic          miss;
        logic [IW-1:0] idx;
    } rd_tag_t;

    state_t          state, state_n;
    logic [1:0]      cnt, cnt_n;
    logic [BW-1:0]   beats, beats_n, beats_inc;
    logic            block, block_n;

    logic            own_dma;
    logic [AW-1:0]   bus_a;
    logic            acc_rd, acc_wr;
    logic [NWIN-1:0] hit_oh;
    logic [IW-1:0]   hit_idx;
    logic            hit_any;
    rd_tag_t         iss_tag, rd_tag;
    logic [DW-1:0]   rd_raw, rd_data;

    assign own_dma   = (state == S_DMA) || (state == S_DMA_WAIT);
    assign bus_a     = own_dma ? dma_a : cpu_a;
    assign s_a       = bus_a;
    assign s_d       = own_dma ? dma_o : cpu_o;
    assign beats_inc = beats + BW'(1);
    assign dbg_state = state;
    assign dbg_block = block;

    // Accesses are issued only in S_CPU and S_DMA; wait states just let data return.
    always_comb begin
        acc_rd = 1'b0;
        acc_wr = 1'b0;
        case (state)
            S_CPU: begin
                acc_rd = cpu_r;
                acc_wr = cpu_w && !cpu_r;
            end
            S_DMA: begin
                acc_rd = dma_req && !dma_w;
                acc_wr = dma_req && dma_w;
            end
            default: ;
        endcase
    end

    // Lowest-index hit wins; a window with base > limit can never match.
    always_comb begin
        hit_oh  = '0;
        hit_idx = '0;
        hit_any = 1'b0;
        for (int k = 0; k < NWIN; k++) begin
            if (!hit_any && (win_base[k*AW +: AW] <= bus_a) && (bus_a <= win_limit[k*AW +: AW])) begin
                hit_oh[k] = 1'b1;
                hit_idx   = IW'(k);
                hit_any   = 1'b1;
            end
        end
    end

    always_comb begin
        iss_tag      = '0;
        iss_tag.vld  = acc_rd;
        iss_tag.dma  = (state == S_DMA);
        iss_tag.miss = !hit_any;
        iss_tag.idx  = hit_idx;
    end

    generate
        if (RD_LAT == 0) begin : g_comb
            assign rd_tag = iss_tag;
        end else begin : g_pipe
            rd_tag_t pipe [RD_LAT];
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= iss_tag;
                    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign rd_tag = pipe[RD_LAT-1];
        end
    endgenerate

    always_comb begin
        rd_raw = '0;
        for (int k = 0; k < NWIN; k++) begin
            if (rd_tag.idx == IW'(k)) rd_raw = s_q[k*DW +: DW];
        end
    end

    assign rd_data = rd_tag.miss ? '1 : rd_raw;
    assign cpu_i   = rd_data;
    assign dma_i   = rd_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_CPU;
            cnt   <= 2'd0;
            beats <= '0;
            block <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            beats <= beats_n;
            block <= block_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beats_n = beats;
        block_n = block;
        case (state)
            S_CPU: begin
                // The CPU cycle that lifts the block is itself the CPU's guaranteed slot.
                block_n = block && !cpu_ce;
                if (cpu_r && RD_STALL) begin
                    state_n = S_CPU_WAIT;
                    cnt_n   = CNT_INIT;
                end else if (dma_req && !block_n) begin
                    state_n = S_DMA;
                    beats_n = '0;
                end
            end
            S_CPU_WAIT: begin
                if (cnt == 2'd0) state_n = S_CPU;
                else             cnt_n   = cnt - 2'd1;
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_n = S_CPU;
                    block_n = 1'b1;
                    beats_n = '0;
                end else begin
                    beats_n = beats_inc;
                    if (!dma_w && RD_STALL) begin
                        state_n = S_DMA_WAIT;
                        cnt_n   = CNT_INIT;
                    end else if (beats_inc == BURST_N) begin
                        state_n = S_CPU;
                        block_n = 1'b1;
                        beats_n = '0;
                    end
                end
            end
            S_DMA_WAIT: begin
                if (cnt != 2'd0) begin
                    cnt_n = cnt - 2'd1;
                end else if ((beats == BURST_N) || !dma_req) begin
                    state_n = S_CPU;
                    block_n = 1'b1;
                    beats_n = '0;
                end else begin
                    state_n = S_DMA;
                end
            end
            default: state_n = S_CPU;
        endcase
    end

    always_comb begin
        cpu_ce  = 1'b1;
        dma_gnt = 1'b0;
        case (state)
            S_CPU:      cpu_ce = !(cpu_r && RD_STALL);
            S_CPU_WAIT: cpu_ce = (cnt == 2'd0);
            S_DMA, S_DMA_WAIT: begin
                cpu_ce  = 1'b0;
                dma_gnt = 1'b1;
            end
            default: ;
        endcase
        s_sel   = (acc_rd || acc_wr) ? hit_oh : '0;
        s_w     = acc_wr ? hit_oh : '0;
        dma_ack = (acc_wr && (state == S_DMA)) || (rd_tag.vld && rd_tag.dma);
        err     = (acc_wr && !hit_any) || (rd_tag.vld && rd_tag.miss);
    end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: three instances with RD_LAT = 0, 1, 2 share one
// stimulus; each step checks only the instance relevant to that step.
module tb_bus_router;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NWIN = 3;
    localparam int BURST = 4;
    localparam int NI = 3;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic [AW-1:0]       cpu_a = '0;
    logic [DW-1:0]       cpu_o = '0;
    logic                cpu_w = 1'b0;
    logic                cpu_r = 1'b0;
    logic                dma_req = 1'b0;
    logic [AW-1:0]       dma_a = '0;
    logic [DW-1:0]       dma_o = '0;
    logic                dma_w = 1'b0;
    logic [NWIN*AW-1:0]  win_base = '0;
    logic [NWIN*AW-1:0]  win_limit = '0;
    logic [NWIN*DW-1:0]  s_q = {8'hC3, 8'hB2, 8'hA1};

    logic [DW-1:0]   cpu_i     [NI];
    logic            cpu_ce    [NI];
    logic            dma_gnt   [NI];
    logic            dma_ack   [NI];
    logic [DW-1:0]   dma_i     [NI];
    logic [AW-1:0]   s_a       [NI];
    logic [DW-1:0]   s_d       [NI];
    logic [NWIN-1:0] s_sel     [NI];
    logic [NWIN-1:0] s_w       [NI];
    logic            err       [NI];
    logic [1:0]      dbg_state [NI];
    logic            dbg_block [NI];

    int n_cmp = 0;
    int n_fail = 0;
    int ack_cnt;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_router #(.AW(AW), .DW(DW), .NWIN(NWIN), .RD_LAT(g), .BURST(BURST)) u_dut (
            .clock(clock), .reset_n(reset_n),
            .cpu_a(cpu_a), .cpu_o(cpu_o), .cpu_w(cpu_w), .cpu_r(cpu_r),
            .cpu_i(cpu_i[g]), .cpu_ce(cpu_ce[g]),
            .dma_req(dma_req), .dma_a(dma_a), .dma_o(dma_o), .dma_w(dma_w),
            .dma_gnt(dma_gnt[g]), .dma_ack(dma_ack[g]), .dma_i(dma_i[g]),
            .win_base(win_base), .win_limit(win_limit),
            .s_a(s_a[g]), .s_d(s_d[g]), .s_sel(s_sel[g]), .s_w(s_w[g]),
            .s_q(s_q), .err(err[g]),
            .dbg_state(dbg_state[g]), .dbg_block(dbg_block[g])
        );
    end

    // Clock / reset
    always #5 clock = ~clock;

    task automatic next_cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_r   = 1'b0;
        cpu_w   = 1'b0;
        cpu_a   = '0;
        cpu_o   = '0;
        dma_req = 1'b0;
        dma_w   = 1'b0;
        dma_a   = '0;
        dma_o   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        next_cyc();
        next_cyc();
        reset_n = 1'b1;
    endtask

    task automatic set_win_split();
        win_base  = {16'h0060, 16'hFC00, 16'h0000};
        win_limit = {16'hFBFF, 16'hFFFF, 16'h005F};
    endtask

    task automatic set_win_overlap();
        win_base  = {16'hFFFF, 16'h0080, 16'h0000};
        win_limit = {16'h0000, 16'h01FF, 16'h00FF};
    endtask

    task automatic cpu_read0(input string tag, input logic [AW-1:0] a,
                             input logic [NWIN-1:0] sel, input logic [DW-1:0] q, input logic e);
        next_cyc();
        cpu_r = 1'b1;
        cpu_w = 1'b0;
        cpu_a = a;
        #2;
        chk({tag, "_sel"}, 32'(s_sel[0]), 32'(sel));
        chk({tag, "_q"},   32'(cpu_i[0]), 32'(q));
        chk({tag, "_ce"},  32'(cpu_ce[0]), 32'(1));
        chk({tag, "_err"}, 32'(err[0]), 32'(e));
        chk({tag, "_w"},   32'(s_w[0]), 32'(0));
    endtask

    initial begin
        // reset state
        set_win_split();
        #2;
        chk("rst_gnt", 32'(dma_gnt[0]), 32'(0));
        chk("rst_ack", 32'(dma_ack[0]), 32'(0));
        chk("rst_err", 32'(err[0]), 32'(0));
        chk("rst_ce", 32'(cpu_ce[0]), 32'(1));
        chk("rst_state", 32'(dbg_state[0]), 32'(0));
        chk("rst_block", 32'(dbg_block[0]), 32'(0));
        do_reset();

        // split windows, zero read latency, including window edges
        cpu_read0("rd_0010", 16'h0010, 3'b001, 8'hA1, 1'b0);
        cpu_read0("rd_fc05", 16'hFC05, 3'b010, 8'hB2, 1'b0);
        cpu_read0("rd_1234", 16'h1234, 3'b100, 8'hC3, 1'b0);
        cpu_read0("rd_005f", 16'h005F, 3'b001, 8'hA1, 1'b0);
        cpu_read0("rd_0060", 16'h0060, 3'b100, 8'hC3, 1'b0);
        cpu_read0("rd_ffff", 16'hFFFF, 3'b010, 8'hB2, 1'b0);

        // RD_LAT=2 CPU read: two stall cycles then data
        do_reset();
        next_cyc();
        cpu_r = 1'b1;
        cpu_a = 16'h0100;
        #2;
        chk("l2_c0_ce", 32'(cpu_ce[2]), 32'(0));
        chk("l2_c0_sel", 32'(s_sel[2]), 32'(3'b100));
        next_cyc();
        #2;
        chk("l2_c1_ce", 32'(cpu_ce[2]), 32'(0));
        chk("l2_c1_state", 32'(dbg_state[2]), 32'(1));
        next_cyc();
        #2;
        chk("l2_c2_ce", 32'(cpu_ce[2]), 32'(1));
        chk("l2_c2_q", 32'(cpu_i[2]), 32'hC3);
        next_cyc();
        cpu_r = 1'b0;
        #2;
        chk("l2_c3_ce", 32'(cpu_ce[2]), 32'(1));
        chk("l2_c3_state", 32'(dbg_state[2]), 32'(0));

        // overlapping windows, misses, invalid window
        do_reset();
        set_win_overlap();
        next_cyc();
        cpu_w = 1'b1;
        cpu_a = 16'h0090;
        cpu_o = 8'h3C;
        #2;
        chk("ov_w_sw", 32'(s_w[0]), 32'(3'b001));
        chk("ov_w_sel", 32'(s_sel[0]), 32'(3'b001));
        chk("ov_w_sd", 32'(s_d[0]), 32'h3C);
        chk("ov_w_sa", 32'(s_a[0]), 32'h0090);
        chk("ov_w_err", 32'(err[0]), 32'(0));
        cpu_read0("miss_0300", 16'h0300, 3'b000, 8'hFF, 1'b1);
        cpu_read0("ov_0150", 16'h0150, 3'b010, 8'hB2, 1'b0);
        cpu_read0("inv_8000", 16'h8000, 3'b000, 8'hFF, 1'b1);
        next_cyc();
        cpu_r = 1'b0;
        cpu_w = 1'b1;
        cpu_a = 16'h0300;
        #2;
        chk("miss_w_err", 32'(err[0]), 32'(1));
        chk("miss_w_sw", 32'(s_w[0]), 32'(0));
        next_cyc();
        idle_inputs();
        #2;
        chk("idle_err", 32'(err[0]), 32'(0));

        // DMA write bursts of 4 with one CPU cycle between them
        do_reset();
        set_win_split();
        ack_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            next_cyc();
            dma_req = 1'b1;
            dma_w   = 1'b1;
            dma_a   = 16'h0020;
            dma_o   = 8'h5A;
            #2;
            chk("bw_gnt", 32'(dma_gnt[0]), 32'((c % 5) != 0));
            chk("bw_ack", 32'(dma_ack[0]), 32'((c % 5) != 0));
            chk("bw_ce", 32'(cpu_ce[0]), 32'((c % 5) == 0));
            if (c < 5 && dma_ack[0]) ack_cnt++;
            if (c == 1) begin
                chk("bw_sw", 32'(s_w[0]), 32'(3'b001));
                chk("bw_sd", 32'(s_d[0]), 32'h5A);
            end
            if (c == 5) chk("bw_block", 32'(dbg_block[0]), 32'(1));
        end
        chk("bw_acks", 32'(ack_cnt), 32'(4));
        next_cyc();
        dma_req = 1'b0;
        #2;
        chk("bw_end_gnt", 32'(dma_gnt[0]), 32'(0));

        // RD_LAT=1 DMA reads; CPU read in the grant cycle goes first
        do_reset();
        next_cyc();
        cpu_r   = 1'b1;
        cpu_a   = 16'hFC05;
        dma_req = 1'b1;
        dma_w   = 1'b0;
        dma_a   = 16'h0010;
        #2;
        chk("l1_c0_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("l1_c0_ce", 32'(cpu_ce[1]), 32'(0));
        next_cyc();
        #2;
        chk("l1_c1_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("l1_c1_ce", 32'(cpu_ce[1]), 32'(1));
        chk("l1_c1_q", 32'(cpu_i[1]), 32'hB2);
        next_cyc();
        cpu_r = 1'b0;
        #2;
        chk("l1_c2_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("l1_c2_ce", 32'(cpu_ce[1]), 32'(1));
        ack_cnt = 0;
        for (int c = 3; c <= 10; c++) begin
            next_cyc();
            #2;
            chk("dr_gnt", 32'(dma_gnt[1]), 32'(1));
            chk("dr_ack", 32'(dma_ack[1]), 32'(((c - 3) % 2) == 1));
            if (c == 3) chk("dr_sel", 32'(s_sel[1]), 32'(3'b001));
            if (dma_ack[1]) begin
                ack_cnt++;
                chk("dr_q", 32'(dma_i[1]), 32'hA1);
            end
        end
        chk("dr_acks", 32'(ack_cnt), 32'(4));
        next_cyc();
        #2;
        chk("dr_c11_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("dr_c11_ce", 32'(cpu_ce[1]), 32'(1));
        next_cyc();
        dma_req = 1'b0;
        #2;
        chk("dr_c12_ack", 32'(dma_ack[1]), 32'(0));
        next_cyc();
        #2;
        chk("dr_c13_gnt", 32'(dma_gnt[1]), 32'(0));

        // dma_req dropped while a read is outstanding: it still acks
        do_reset();
        next_cyc();
        dma_req = 1'b1;
        dma_w   = 1'b0;
        dma_a   = 16'hFC05;
        next_cyc();
        #2;
        chk("drop_c1_gnt", 32'(dma_gnt[1]), 32'(1));
        chk("drop_c1_ack", 32'(dma_ack[1]), 32'(0));
        next_cyc();
        dma_req = 1'b0;
        #2;
        chk("drop_c2_ack", 32'(dma_ack[1]), 32'(1));
        chk("drop_c2_q", 32'(dma_i[1]), 32'hB2);
        next_cyc();
        #2;
        chk("drop_c3_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("drop_c3_ce", 32'(cpu_ce[1]), 32'(1));
        chk("drop_c3_ack", 32'(dma_ack[1]), 32'(0));

        // async reset during S_DMA_WAIT
        do_reset();
        next_cyc();
        dma_req = 1'b1;
        dma_w   = 1'b0;
        dma_a   = 16'h0010;
        next_cyc();
        next_cyc();
        #2;
        chk("ar_pre_state", 32'(dbg_state[1]), 32'(3));
        chk("ar_pre_gnt", 32'(dma_gnt[1]), 32'(1));
        reset_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(dma_gnt[1]), 32'(0));
        chk("ar_ce", 32'(cpu_ce[1]), 32'(1));
        chk("ar_ack", 32'(dma_ack[1]), 32'(0));
        chk("ar_err", 32'(err[1]), 32'(0));
        chk("ar_state", 32'(dbg_state[1]), 32'(0));
        next_cyc();
        #2;
        chk("ar_next_ack", 32'(dma_ack[1]), 32'(0));
        idle_inputs();
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_router.md
# bus_router

Parametrised data-bus router and two-master arbiter for the AVR SoC. It decodes the shared data address into NWIN configurable windows and generates one-hot select and write strobes. Read data is muxed back with a configurable memory read latency. A DMA master (SD buffer engine, video copier) can borrow the bus in bounded bursts while the CPU is stalled through its `ce` input. It sits between the `avr` core, the block RAMs and the peripheral/port space in the top level, and replaces hand-written `m_pt`/`m_sd` decode chains.

## Interface
- AW, 16: address width.
- DW, 8: data width.
- NWIN, 4: number of decode windows (1..8).
- RD_LAT, 0: slave read latency in cycles (0..3). 0 means combinational `s_q` in the same cycle.
- BURST, 4: maximum consecutive DMA beats per grant (1..16).

- clock  in  1  system clock; all state on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_a / cpu_o  in  AW / DW  CPU address / write data
- cpu_w / cpu_r  in  1 / 1  CPU write / read request
- cpu_i  out  DW  CPU read data
- cpu_ce  out  1  CPU clock enable; 0 stalls the core
- dma_req  in  1  DMA wants the bus (level)
- dma_a / dma_o / dma_w  in  AW / DW / 1  DMA address, write data, write (0 = read)
- dma_gnt  out  1  DMA owns the bus this cycle
- dma_ack  out  1  one-cycle strobe: beat complete; read data on dma_i
- dma_i  out  DW  DMA read data
- win_base / win_limit  in  NWIN*AW / NWIN*AW  inclusive window bounds; window k at [k*AW +: AW]; quasi-static
- s_a / s_d  out  AW / DW  slave address / write data (from current owner)
- s_sel / s_w  out  NWIN / NWIN  one-hot select / write strobe
- s_q  in  NWIN*DW  slave read data, window k at [k*DW +: DW]
- err  out  1  one-cycle strobe: access matched no window

## Operation
- Decode: window k hits when base_k <= addr <= limit_k (unsigned). On overlap, the lowest index wins. s_sel is one-hot or all-zero. s_w = sel & owner_write.
- Miss: write is dropped. Read returns all-ones (DW'hFF..). err pulses in the data cycle.
- Read mux: the selected index is delayed through an RD_LAT-deep pipeline, together with a miss flag and an owner tag. Data is taken from s_q of the delayed index.
- States: S_CPU, S_CPU_WAIT, S_DMA, S_DMA_WAIT.
- S_CPU:
  - Bus driven from cpu_*.
  - cpu_ce=1, except a cpu_r with RD_LAT>0 sets cpu_ce=0 and moves to S_CPU_WAIT with cnt=RD_LAT-1.
  - Otherwise, if dma_req && !block, move to S_DMA.
  - A CPU read takes priority over a grant.
- S_CPU_WAIT:
  - cpu_ce=0 and the CPU holds its address.
  - Decrement cnt. When cnt==0, cpu_ce=1 and cpu_i is valid that cycle. Then return to S_CPU.
- S_DMA:
  - dma_gnt=1, bus driven from dma_*, cpu_ce=0.
  - Write beat: dma_ack=1 the same cycle.
  - Read beat: with RD_LAT=0, ack the same cycle. Otherwise go to S_DMA_WAIT and ack with dma_i at issue+RD_LAT.
  - beats increments per beat. On beats==BURST or dma_req low, return to S_CPU and set block=1.
- S_DMA_WAIT: dma_gnt=1, cpu_ce=0. Return to S_DMA, or to S_CPU if the burst ended.
- block clears after the first S_CPU cycle with cpu_ce=1. This guarantees the CPU one access between bursts.

## Timing
- Reset values: state=S_CPU, cnt=0, beats=0, block=0, pipeline flags=0, dma_gnt=0, dma_ack=0, err=0, cpu_ce=1.
- Combinational outputs: s_a, s_d, s_sel, s_w.
- Read data path: cpu_i/dma_i are combinational from s_q (no extra register).
- CPU read latency: RD_LAT stall cycles.
- DMA latency: grant is 1 cycle after dma_req is seen in S_CPU. Each beat costs 1 cycle (write) or 1+RD_LAT cycles (read).
- dma_req dropped mid-wait: the outstanding read still acks, then control returns to S_CPU.
- Async reset mid-burst: returns to S_CPU at once, drops the pending ack, no err.
- Invalid config (base>limit): the window never hits.

## Test plan
- NWIN=3, windows [0000-005F], [FC00-FFFF], [0060-FBFF], RD_LAT=0. CPU reads 0x0010, 0xFC05, 0x1234 -> s_sel 001, 010, 100; cpu_i equals the matching s_q slice in the same cycle; cpu_ce stays 1.
- RD_LAT=2, CPU read 0x0100 -> cpu_ce=0 for 2 cycles, 1 on the third; cpu_i = s_q[2] value.
- Overlap: win0=[0000-00FF], win1=[0080-01FF], write 0x0090 -> s_w=01 only. Unmapped 0x0300 read -> cpu_i=FF, err pulse, s_w=0.
- BURST=4, dma_req held 10 cycles of writes -> 4 acks. Then exactly 1 CPU cycle with cpu_ce=1, then regrant.
- RD_LAT=1, DMA read of 4 beats -> dma_ack every 2nd cycle with correct data. CPU read issued in the grant cycle -> CPU served first.
- Assert reset_n low during S_DMA_WAIT -> dma_gnt=0 and cpu_ce=1 immediately, no dma_ack.
